// File: rtl/issue_stage.sv
// issue_stage: in-order dual-issue stage. A hold register keeps one fetched
// instruction pair. A 128-entry latency scoreboard decides when A and B
// may leave. Each issued instruction is steered to the even or odd pipe.
module issue_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [0:31] instruction_a,
    input  logic [0:31] instruction_b,
    input  logic [7:0]  program_counter,
    input  logic        pipe_a,
    input  logic        pipe_b,
    input  logic [6:0]  rt_a,
    input  logic [6:0]  rt_b,
    input  logic [2:0]  src_use_a,
    input  logic [2:0]  src_use_b,
    input  logic [2:0]  latency_a,
    input  logic [2:0]  latency_b,
    input  logic        branch_is_taken,
    output logic [0:31] instruction_even,
    output logic [0:31] instruction_odd,
    output logic [7:0]  program_counter_issue,
    output logic        initial_odd
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_PAIR     = 2'd1,
        ST_SINGLE_B = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    // Held pair and its side-band fields.
    logic [0:31] hold_instr_a_r;
    logic [0:31] hold_instr_b_r;
    logic [7:0]  hold_pc_r;
    logic        hold_pipe_a_r;
    logic        hold_pipe_b_r;
    logic [6:0]  hold_rt_a_r;
    logic [6:0]  hold_rt_b_r;
    logic [2:0]  hold_use_a_r;
    logic [2:0]  hold_use_b_r;
    logic [2:0]  hold_lat_a_r;
    logic [2:0]  hold_lat_b_r;

    // Scoreboard: a register is free once its countdown reaches zero.
    logic [2:0]  sb_r [0:127];

    // Registered pipe outputs.
    logic [0:31] instr_even_r;
    logic [0:31] instr_odd_r;
    logic [7:0]  pc_issue_r;
    logic        initial_odd_r;

    logic [0:31] instr_even_s;
    logic [0:31] instr_odd_s;
    logic [7:0]  pc_issue_s;
    logic        initial_odd_s;

    logic        ready_a_s;
    logic        ready_b_s;
    logic        issue_a_s;
    logic        issue_b_s;
    logic        all_issued_s;
    logic        fetch_ready_s;
    logic        accept_s;
    logic        load_a_s;
    logic        load_b_s;

    // True when any source field selected by use_bits names reg_idx.
    function automatic logic reads_reg(
        input logic [0:31] instr,
        input logic [2:0]  use_bits,
        input logic [6:0]  reg_idx
    );
        reads_reg = (use_bits[2] && (instr[18:24] == reg_idx)) ||
                    (use_bits[1] && (instr[11:17] == reg_idx)) ||
                    (use_bits[0] && (instr[25:31] == reg_idx));
    endfunction

    // True when every used source is free and, for a writer, the destination is free.
    function automatic logic slot_ready(
        input logic [2:0] use_bits,
        input logic [2:0] cnt_ra,
        input logic [2:0] cnt_rb,
        input logic [2:0] cnt_rc,
        input logic [2:0] lat,
        input logic [2:0] cnt_rt
    );
        slot_ready = (!use_bits[2] || (cnt_ra == 3'd0)) &&
                     (!use_bits[1] || (cnt_rb == 3'd0)) &&
                     (!use_bits[0] || (cnt_rc == 3'd0)) &&
                     ((lat == 3'd0) || (cnt_rt == 3'd0));
    endfunction

    // Scoreboard lookups for both held slots.
    always_comb begin
        ready_a_s = slot_ready(hold_use_a_r,
                               sb_r[hold_instr_a_r[18:24]],
                               sb_r[hold_instr_a_r[11:17]],
                               sb_r[hold_instr_a_r[25:31]],
                               hold_lat_a_r,
                               sb_r[hold_rt_a_r]);
        ready_b_s = slot_ready(hold_use_b_r,
                               sb_r[hold_instr_b_r[18:24]],
                               sb_r[hold_instr_b_r[11:17]],
                               sb_r[hold_instr_b_r[25:31]],
                               hold_lat_b_r,
                               sb_r[hold_rt_b_r]);
    end

    // Issue decision: A first, B alongside only without pipe or RAW conflict.
    always_comb begin
        issue_a_s    = 1'b0;
        issue_b_s    = 1'b0;
        all_issued_s = 1'b0;
        case (state_r)
            ST_PAIR: begin
                if (!branch_is_taken && ready_a_s) begin
                    issue_a_s = 1'b1;
                    if ((hold_pipe_b_r != hold_pipe_a_r) && ready_b_s &&
                        !((hold_lat_a_r != 3'd0) &&
                          reads_reg(hold_instr_b_r, hold_use_b_r, hold_rt_a_r))) begin
                        issue_b_s    = 1'b1;
                        all_issued_s = 1'b1;
                    end else begin
                        issue_b_s    = 1'b0;
                        all_issued_s = 1'b0;
                    end
                end else begin
                    issue_a_s = 1'b0;
                end
            end
            ST_SINGLE_B: begin
                if (!branch_is_taken && ready_b_s) begin
                    issue_b_s    = 1'b1;
                    all_issued_s = 1'b1;
                end else begin
                    issue_b_s    = 1'b0;
                    all_issued_s = 1'b0;
                end
            end
            ST_EMPTY: begin
                all_issued_s = 1'b0;
            end
            default: begin
                all_issued_s = 1'b0;
            end
        endcase
    end

    // Fetch handshake: take a new pair when the hold is empty or drains this cycle.
    always_comb begin
        fetch_ready_s = 1'b0;
        if (reset || branch_is_taken) begin
            fetch_ready_s = 1'b0;
        end else begin
            fetch_ready_s = (state_r == ST_EMPTY) || all_issued_s;
        end
        accept_s = fetch_valid && fetch_ready_s;
        load_a_s = issue_a_s && (hold_lat_a_r != 3'd0);
        load_b_s = issue_b_s && (hold_lat_b_r != 3'd0);
    end

    assign fetch_ready = fetch_ready_s;

    // Next-state logic for the hold register.
    always_comb begin
        state_s = state_r;
        if (branch_is_taken) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    state_s = accept_s ? ST_PAIR : ST_EMPTY;
                end
                ST_PAIR: begin
                    if (all_issued_s) begin
                        state_s = accept_s ? ST_PAIR : ST_EMPTY;
                    end else if (issue_a_s) begin
                        state_s = ST_SINGLE_B;
                    end else begin
                        state_s = ST_PAIR;
                    end
                end
                ST_SINGLE_B: begin
                    if (all_issued_s) begin
                        state_s = accept_s ? ST_PAIR : ST_EMPTY;
                    end else begin
                        state_s = ST_SINGLE_B;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Steer issued instructions to their pipes; the program counter holds when nothing issues.
    always_comb begin
        instr_even_s  = 32'd0;
        instr_odd_s   = 32'd0;
        pc_issue_s    = pc_issue_r;
        initial_odd_s = 1'b0;
        if (issue_a_s) begin
            pc_issue_s    = hold_pc_r;
            initial_odd_s = hold_pipe_a_r;
            if (hold_pipe_a_r) begin
                instr_odd_s = hold_instr_a_r;
            end else begin
                instr_even_s = hold_instr_a_r;
            end
            if (issue_b_s) begin
                if (hold_pipe_b_r) begin
                    instr_odd_s = hold_instr_b_r;
                end else begin
                    instr_even_s = hold_instr_b_r;
                end
            end else begin
                pc_issue_s = hold_pc_r;
            end
        end else if (issue_b_s) begin
            pc_issue_s    = hold_pc_r + 8'd1;
            initial_odd_s = hold_pipe_b_r;
            if (hold_pipe_b_r) begin
                instr_odd_s = hold_instr_b_r;
            end else begin
                instr_even_s = hold_instr_b_r;
            end
        end else begin
            initial_odd_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Hold register capture on an accepted pair.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_instr_a_r <= 32'd0;
            hold_instr_b_r <= 32'd0;
            hold_pc_r      <= 8'd0;
            hold_pipe_a_r  <= 1'b0;
            hold_pipe_b_r  <= 1'b0;
            hold_rt_a_r    <= 7'd0;
            hold_rt_b_r    <= 7'd0;
            hold_use_a_r   <= 3'd0;
            hold_use_b_r   <= 3'd0;
            hold_lat_a_r   <= 3'd0;
            hold_lat_b_r   <= 3'd0;
        end else if (accept_s) begin
            hold_instr_a_r <= instruction_a;
            hold_instr_b_r <= instruction_b;
            hold_pc_r      <= program_counter;
            hold_pipe_a_r  <= pipe_a;
            hold_pipe_b_r  <= pipe_b;
            hold_rt_a_r    <= rt_a;
            hold_rt_b_r    <= rt_b;
            hold_use_a_r   <= src_use_a;
            hold_use_b_r   <= src_use_b;
            hold_lat_a_r   <= latency_a;
            hold_lat_b_r   <= latency_b;
        end
    end

    // Scoreboard countdown; an issue load beats the decrement, B's load beats A's.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                sb_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 128; i++) begin
                if (load_b_s && (hold_rt_b_r == 7'(i))) begin
                    sb_r[i] <= hold_lat_b_r;
                end else if (load_a_s && (hold_rt_a_r == 7'(i))) begin
                    sb_r[i] <= hold_lat_a_r;
                end else if (sb_r[i] != 3'd0) begin
                    sb_r[i] <= sb_r[i] - 3'd1;
                end
            end
        end
    end

    // Output registers, one cycle after the issue decision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_even_r  <= 32'd0;
            instr_odd_r   <= 32'd0;
            pc_issue_r    <= 8'd0;
            initial_odd_r <= 1'b0;
        end else begin
            instr_even_r  <= instr_even_s;
            instr_odd_r   <= instr_odd_s;
            pc_issue_r    <= pc_issue_s;
            initial_odd_r <= initial_odd_s;
        end
    end

    assign instruction_even      = instr_even_r;
    assign instruction_odd       = instr_odd_r;
    assign program_counter_issue = pc_issue_r;
    assign initial_odd           = initial_odd_r;

endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: directed scenarios plus random traffic, checked against a
// queue-based reference model of the issue rules.
module tb_issue_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [0:31] instruction_a = 32'd0;
    logic [0:31] instruction_b = 32'd0;
    logic [7:0]  program_counter = 8'd0;
    logic        pipe_a = 1'b0;
    logic        pipe_b = 1'b0;
    logic [6:0]  rt_a = 7'd0;
    logic [6:0]  rt_b = 7'd0;
    logic [2:0]  src_use_a = 3'd0;
    logic [2:0]  src_use_b = 3'd0;
    logic [2:0]  latency_a = 3'd0;
    logic [2:0]  latency_b = 3'd0;
    logic        branch_is_taken = 1'b0;
    logic [0:31] instruction_even;
    logic [0:31] instruction_odd;
    logic [7:0]  program_counter_issue;
    logic        initial_odd;

    always #5 clock = ~clock;

    issue_stage dut (
        .clock                 (clock),
        .reset                 (reset),
        .fetch_valid           (fetch_valid),
        .fetch_ready           (fetch_ready),
        .instruction_a         (instruction_a),
        .instruction_b         (instruction_b),
        .program_counter       (program_counter),
        .pipe_a                (pipe_a),
        .pipe_b                (pipe_b),
        .rt_a                  (rt_a),
        .rt_b                  (rt_b),
        .src_use_a             (src_use_a),
        .src_use_b             (src_use_b),
        .latency_a             (latency_a),
        .latency_b             (latency_b),
        .branch_is_taken       (branch_is_taken),
        .instruction_even      (instruction_even),
        .instruction_odd       (instruction_odd),
        .program_counter_issue (program_counter_issue),
        .initial_odd           (initial_odd)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [0:31] instr;
        logic        pipe;
        logic [6:0]  rt;
        logic [2:0]  use_bits;
        int          lat;
        logic [7:0]  pc;
    } ent_t;

    ent_t        q[$];
    int          sb[128];
    logic [31:0] exp_even;
    logic [31:0] exp_odd;
    logic [7:0]  exp_pc;
    logic        exp_init;

    function automatic bit ent_reads(ent_t e, logic [6:0] r);
        return (e.use_bits[2] && e.instr[18:24] == r) ||
               (e.use_bits[1] && e.instr[11:17] == r) ||
               (e.use_bits[0] && e.instr[25:31] == r);
    endfunction

    function automatic bit ent_ready(ent_t e);
        if (e.use_bits[2] && sb[e.instr[18:24]] != 0) return 1'b0;
        if (e.use_bits[1] && sb[e.instr[11:17]] != 0) return 1'b0;
        if (e.use_bits[0] && sb[e.instr[25:31]] != 0) return 1'b0;
        if (e.lat != 0 && sb[e.rt] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_issue_count();
        int n = 0;
        if (reset || branch_is_taken || q.size() == 0) return 0;
        if (ent_ready(q[0])) begin
            n = 1;
            if (q.size() == 2 && ent_ready(q[1]) && q[1].pipe != q[0].pipe &&
                !(q[0].lat != 0 && ent_reads(q[1], q[0].rt)))
                n = 2;
        end
        return n;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < 128; r++) sb[r] = 0;
        exp_even = 32'd0;
        exp_odd  = 32'd0;
        exp_pc   = 8'd0;
        exp_init = 1'b0;
    endtask

    task automatic model_commit(input int n, input bit rdy);
        ent_t issued[$];
        ent_t e;
        for (int i = 0; i < n; i++) issued.push_back(q.pop_front());
        exp_even = 32'd0;
        exp_odd  = 32'd0;
        exp_init = 1'b0;
        if (n > 0) begin
            exp_pc   = issued[0].pc;
            exp_init = issued[0].pipe;
            foreach (issued[k]) begin
                if (issued[k].pipe) exp_odd = issued[k].instr;
                else                exp_even = issued[k].instr;
            end
        end
        if (branch_is_taken) q.delete();
        for (int r = 0; r < 128; r++) if (sb[r] > 0) sb[r]--;
        foreach (issued[k]) if (issued[k].lat > 0) sb[issued[k].rt] = issued[k].lat;
        if (fetch_valid && rdy) begin
            e.instr = instruction_a; e.pipe = pipe_a; e.rt = rt_a;
            e.use_bits = src_use_a; e.lat = int'(latency_a); e.pc = program_counter;
            q.push_back(e);
            e.instr = instruction_b; e.pipe = pipe_b; e.rt = rt_b;
            e.use_bits = src_use_b; e.lat = int'(latency_b); e.pc = program_counter + 8'd1;
            q.push_back(e);
        end
    endtask

    // One clock: inputs already driven just after a falling edge.
    task automatic run_cycle();
        int  n;
        bit  rdy;
        #1;
        n   = model_issue_count();
        rdy = !reset && !branch_is_taken && (q.size() == 0 || n == q.size());
        check_eq("fetch_ready", fetch_ready, rdy);
        model_commit(n, rdy);
        @(negedge clock);
        check_eq("even", instruction_even, exp_even);
        check_eq("odd", instruction_odd, exp_odd);
        check_eq("pc_issue", program_counter_issue, exp_pc);
        check_eq("initial_odd", initial_odd, exp_init);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch_valid = 1'b0;
        branch_is_taken = 1'b0;
        #1;
        check_eq("rst_even", instruction_even, 32'd0);
        check_eq("rst_odd", instruction_odd, 32'd0);
        check_eq("rst_pc", program_counter_issue, 32'd0);
        check_eq("rst_initial_odd", initial_odd, 32'd0);
        check_eq("rst_fetch_ready", fetch_ready, 32'd0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [0:31] mk_instr(input logic [6:0] ra, input logic [6:0] rb,
                                             input logic [6:0] rc, input logic [31:0] filler);
        logic [0:31] x;
        x = filler;
        x[18:24] = ra;
        x[11:17] = rb;
        x[25:31] = rc;
        return x;
    endfunction

    task automatic offer(input logic [0:31] ia, input logic [0:31] ib, input logic [7:0] pc,
                         input logic pa, input logic pb, input logic [6:0] ta, input logic [6:0] tb,
                         input logic [2:0] ua, input logic [2:0] ub,
                         input logic [2:0] la, input logic [2:0] lb);
        fetch_valid = 1'b1;
        instruction_a = ia; instruction_b = ib; program_counter = pc;
        pipe_a = pa; pipe_b = pb; rt_a = ta; rt_b = tb;
        src_use_a = ua; src_use_b = ub; latency_a = la; latency_b = lb;
    endtask

    logic [0:31] ia;
    logic [0:31] ib;
    logic [0:31] ic;

    initial begin
        model_reset();
        #2;
        do_reset();

        // Independent pair: A even writes r5, B odd.
        ia = mk_instr(7'd1, 7'd2, 7'd3, 32'h11000000);
        ib = mk_instr(7'd4, 7'd0, 7'd0, 32'h22000000);
        offer(ia, ib, 8'h10, 1'b0, 1'b1, 7'd5, 7'd6, 3'b111, 3'b100, 3'd2, 3'd1);
        run_cycle();
        fetch_valid = 1'b0;
        run_cycle();
        check_eq("p20_even", instruction_even, ia);
        check_eq("p20_odd", instruction_odd, ib);
        check_eq("p20_pc", program_counter_issue, 32'h10);
        check_eq("p20_init", initial_odd, 32'd0);

        // RAW within pair on r7 with latency 3.
        ia = mk_instr(7'd1, 7'd0, 7'd0, 32'h33000000);
        ib = mk_instr(7'd7, 7'd0, 7'd0, 32'h44000000);
        offer(ia, ib, 8'h10, 1'b0, 1'b1, 7'd7, 7'd8, 3'b100, 3'b100, 3'd3, 3'd1);
        run_cycle();
        fetch_valid = 1'b0;
        run_cycle();
        check_eq("raw_a_even", instruction_even, ia);
        check_eq("raw_a_odd", instruction_odd, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("raw_stall_ready", fetch_ready, 32'd0);
            run_cycle();
            check_eq("raw_stall_odd", instruction_odd, 32'd0);
        end
        run_cycle();
        check_eq("raw_b_odd", instruction_odd, ib);
        check_eq("raw_b_pc", program_counter_issue, 32'h11);
        check_eq("raw_b_init", initial_odd, 32'd1);

        // Structural: both even.
        ia = mk_instr(7'd1, 7'd0, 7'd0, 32'h55000000);
        ib = mk_instr(7'd2, 7'd0, 7'd0, 32'h66000000);
        offer(ia, ib, 8'h40, 1'b0, 1'b0, 7'd9, 7'd0, 3'b100, 3'b100, 3'd1, 3'd0);
        run_cycle();
        fetch_valid = 1'b0;
        run_cycle();
        check_eq("str_a_even", instruction_even, ia);
        check_eq("str_a_odd", instruction_odd, 32'd0);
        run_cycle();
        check_eq("str_b_even", instruction_even, ib);
        check_eq("str_b_pc", program_counter_issue, 32'h41);

        // Reversed order: A odd, B even.
        ia = mk_instr(7'd1, 7'd0, 7'd0, 32'h77000000);
        ib = mk_instr(7'd2, 7'd0, 7'd0, 32'h88000000);
        offer(ia, ib, 8'h50, 1'b1, 1'b0, 7'd11, 7'd12, 3'b100, 3'b100, 3'd2, 3'd0);
        run_cycle();
        fetch_valid = 1'b0;
        run_cycle();
        check_eq("rev_odd", instruction_odd, ia);
        check_eq("rev_even", instruction_even, ib);
        check_eq("rev_init", initial_odd, 32'd1);

        // Flush during SINGLE_B stall; the r7 counter must keep running.
        ia = mk_instr(7'd1, 7'd0, 7'd0, 32'h99000000);
        ib = mk_instr(7'd7, 7'd0, 7'd0, 32'hAA000000);
        offer(ia, ib, 8'h60, 1'b0, 1'b1, 7'd7, 7'd8, 3'b100, 3'b100, 3'd3, 3'd0);
        run_cycle();
        fetch_valid = 1'b0;
        run_cycle();
        offer(mk_instr(7'd3, 7'd0, 7'd0, 32'hBB000000), ib, 8'h70,
              1'b0, 1'b1, 7'd0, 7'd0, 3'b100, 3'b000, 3'd0, 3'd0);
        branch_is_taken = 1'b1;
        run_cycle();
        branch_is_taken = 1'b0;
        check_eq("fl_even", instruction_even, 32'd0);
        check_eq("fl_odd", instruction_odd, 32'd0);
        ic = mk_instr(7'd7, 7'd0, 7'd0, 32'hCC000000);
        offer(ic, mk_instr(7'd2, 7'd0, 7'd0, 32'hDD000000), 8'h80,
              1'b0, 1'b1, 7'd0, 7'd0, 3'b100, 3'b100, 3'd0, 3'd0);
        run_cycle();
        fetch_valid = 1'b0;
        run_cycle();
        check_eq("fl_sb_hold", instruction_even, 32'd0);
        run_cycle();
        check_eq("fl_sb_done", instruction_even, ic);

        // Reset during a PAIR stall.
        ia = mk_instr(7'd1, 7'd0, 7'd0, 32'hE1000000);
        ib = mk_instr(7'd2, 7'd0, 7'd0, 32'hE2000000);
        offer(ia, ib, 8'h90, 1'b0, 1'b1, 7'd10, 7'd0, 3'b100, 3'b100, 3'd7, 3'd0);
        run_cycle();
        offer(mk_instr(7'd10, 7'd0, 7'd0, 32'hE3000000), ib, 8'hA0,
              1'b0, 1'b1, 7'd0, 7'd0, 3'b100, 3'b100, 3'd0, 3'd0);
        run_cycle();
        fetch_valid = 1'b0;
        check_eq("rs_pre_even", instruction_even, ia);
        do_reset();
        for (int i = 0; i < 12; i++) run_cycle();

        // Random traffic over a small register window to force hazards.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            fetch_valid     = ($urandom_range(0, 3) != 0);
            branch_is_taken = ($urandom_range(0, 15) == 0);
            instruction_a   = mk_instr(7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                                       7'($urandom_range(0, 7)), $urandom);
            instruction_b   = mk_instr(7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                                       7'($urandom_range(0, 7)), $urandom);
            program_counter = 8'($urandom_range(0, 255));
            pipe_a          = 1'($urandom_range(0, 1));
            pipe_b          = 1'($urandom_range(0, 1));
            rt_a            = 7'($urandom_range(0, 7));
            rt_b            = 7'($urandom_range(0, 7));
            src_use_a       = 3'($urandom_range(0, 7));
            src_use_b       = 3'($urandom_range(0, 7));
            latency_a       = 3'($urandom_range(0, 7));
            latency_b       = 3'($urandom_range(0, 7));
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
